// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg: shared types and constants for the SRAM responder slice
package sram_responder_pkg;
  localparam int MEM_WORD_W = 16;
  typedef logic [1:0] lane_t;
  typedef enum logic [2:0] {IDLE, RD, RD_HOLD, WR, WR_DONE} mem_state_e;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SLC-3 memory bus between control unit (master) and responder (slave)
interface sram_responder_if import sram_responder_pkg::*;;
  logic [15:0] Addr;
  logic [MEM_WORD_W-1:0] Data_in;
  logic [MEM_WORD_W-1:0] Data_out;
  logic Mem_CE;
  logic Mem_OE;
  logic Mem_WE;
  logic Mem_UB;
  logic Mem_LB;
  logic Data_valid;
  logic Busy;
  logic Err;
  modport master (
    output Addr, Data_in, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
    input Data_out, Data_valid, Busy, Err
  );
  modport slave (
    input Addr, Data_in, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
    output Data_out, Data_valid, Busy, Err
  );
endinterface

// File: rtl/sram_array.sv
// sram_array: word RAM with one byte-enabled sync write port and one registered read port
module sram_array import sram_responder_pkg::*; #(
  parameter int AW = 10
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  we,
  input  lane_t                 be,
  input  logic [AW-1:0]         waddr,
  input  logic [MEM_WORD_W-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [MEM_WORD_W-1:0] rdata
);
  logic [MEM_WORD_W-1:0] mem [2**AW];
  always_ff @(posedge Clk) begin
    if (we && be[0]) mem[waddr][7:0] <= wdata[7:0];
    if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
  end
  always_ff @(posedge Clk) begin
    if (Reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: decodes the active-low SLC-3 memory bus into timed reads/byte-laned writes on word RAM
module sram_responder import sram_responder_pkg::*; #(
  parameter int AW        = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sram_responder_if.slave       bus,
  input  logic                  Init_en,
  input  logic [AW-1:0]         Init_addr,
  input  logic [MEM_WORD_W-1:0] Init_data
);
  localparam logic [3:0] RL1 = 4'(READ_LAT - 1);
  localparam logic [3:0] WL1 = 4'(WRITE_LAT - 1);
  mem_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] addr_q, a_bus;
  logic valid_q, valid_n, err_q;
  logic rd, wr, bad, same, rd_ok, wr_ok, commit, re;
  assign a_bus  = bus.Addr[AW-1:0];
  assign rd     = ~bus.Mem_CE & ~bus.Mem_OE &  bus.Mem_WE;
  assign wr     = ~bus.Mem_CE & ~bus.Mem_WE &  bus.Mem_OE;
  assign bad    = ~bus.Mem_CE & ~bus.Mem_OE & ~bus.Mem_WE;
  assign same   = a_bus == addr_q;
  assign rd_ok  = rd & (state == IDLE | same);
  assign wr_ok  = wr & ~Init_en & (state == IDLE | same);
  assign commit = wr_ok & ((state == WR & cnt == WL1) | (state == IDLE & WRITE_LAT == 1));
  assign re      = state_n == RD | state_n == RD_HOLD;
  assign valid_n = state_n == RD_HOLD | (state_n == RD & cnt_n == RL1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bad) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = rd_ok ? RD : wr_ok ? (commit ? WR_DONE : WR) : IDLE;
          cnt_n   = (rd_ok | wr_ok) ? 4'd1 : 4'd0;
        end
        RD: begin
          state_n = !rd_ok ? IDLE : cnt == RL1 ? RD_HOLD : RD;
          cnt_n   = rd_ok ? cnt + 4'd1 : 4'd0;
        end
        RD_HOLD: state_n = rd_ok ? RD_HOLD : IDLE;
        WR: begin
          state_n = !wr_ok ? IDLE : commit ? WR_DONE : WR;
          cnt_n   = wr_ok ? cnt + 4'd1 : 4'd0;
        end
        WR_DONE: state_n = (wr & same) ? WR_DONE : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= state == IDLE ? a_bus : addr_q;
      valid_q <= valid_n;
      err_q   <= err_q | bad;
    end
  end
  assign bus.Data_valid = valid_q;
  assign bus.Busy       = state != IDLE;
  assign bus.Err        = err_q;
  sram_array #(.AW(AW)) u_array (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (Init_en | (commit & ~Reset)),
    .be    (Init_en ? 2'b11 : {~bus.Mem_UB, ~bus.Mem_LB}),
    .waddr (Init_en ? Init_addr : a_bus),
    .wdata (Init_en ? Init_data : bus.Data_in),
    .re    (re & ~Reset),
    .raddr (a_bus),
    .rdata (bus.Data_out)
  );
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: scoreboard bench for the SLC-3 memory responder
module tb_sram_responder;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Init_en = 1'b0;
  logic [9:0] Init_addr = '0;
  logic [15:0] Init_data = '0;
  int tests = 0;
  int fails = 0;
  logic [15:0] mdl [1024];
  logic [15:0] exp_q [$];
  sram_responder_if bus();
  sram_responder #(.AW(10), .READ_LAT(2), .WRITE_LAT(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Init_en   (Init_en),
    .Init_addr (Init_addr),
    .Init_data (Init_data)
  );
  always #5 Clk = ~Clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask
  task automatic bus_idle;
    bus.Mem_CE = 1'b1;
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b1;
    bus.Mem_LB = 1'b1;
  endtask
  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic oe, input logic we, input logic ub, input logic lb);
    bus.Addr = a;
    bus.Data_in = d;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = oe;
    bus.Mem_WE = we;
    bus.Mem_UB = ub;
    bus.Mem_LB = lb;
  endtask
  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    Init_en = 1'b1;
    Init_addr = a;
    Init_data = d;
    mdl[a] = d;
    tick;
    Init_en = 1'b0;
  endtask
  task automatic do_read(input logic [15:0] a, input string nm);
    int n;
    logic [15:0] want;
    drive(a, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(mdl[a[9:0]]);
    chk({nm, "_c1_valid"}, {15'b0, bus.Data_valid}, 16'h0);
    tick;
    n = 0;
    while (bus.Data_valid !== 1'b1 && n < 8) begin
      tick;
      n++;
    end
    want = exp_q.pop_front();
    chk({nm, "_latency"}, 16'(n), 16'h0);
    chk({nm, "_busy"}, {15'b0, bus.Busy}, 16'h1);
    chk({nm, "_data"}, bus.Data_out, want);
    tick;
    if (n == 0) begin
      chk({nm, "_hold_valid"}, {15'b0, bus.Data_valid}, 16'h1);
      chk({nm, "_hold_data"}, bus.Data_out, want);
    end
    bus_idle;
    tick;
    chk({nm, "_end_valid"}, {15'b0, bus.Data_valid}, 16'h0);
    chk({nm, "_end_data"}, bus.Data_out, want);
    chk({nm, "_end_busy"}, {15'b0, bus.Busy}, 16'h0);
  endtask
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic ub, input logic lb, input string nm);
    drive(a, d, 1'b1, 1'b0, ub, lb);
    tick;
    chk({nm, "_busy_wr"}, {15'b0, bus.Busy}, 16'h1);
    tick;
    chk({nm, "_busy_done"}, {15'b0, bus.Busy}, 16'h1);
    if (!lb) mdl[a[9:0]][7:0] = d[7:0];
    if (!ub) mdl[a[9:0]][15:8] = d[15:8];
    bus_idle;
    tick;
    chk({nm, "_idle"}, {15'b0, bus.Busy}, 16'h0);
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
    chk("rst_data", bus.Data_out, 16'h0);
    chk("rst_valid", {15'b0, bus.Data_valid}, 16'h0);
    chk("rst_busy", {15'b0, bus.Busy}, 16'h0);
    chk("rst_err", {15'b0, bus.Err}, 16'h0);
  endtask
  task automatic test_read;
    preload(10'h005, 16'h1234);
    do_read(16'h0005, "read5");
    preload(10'h006, 16'hA5C3);
    do_read(16'h0006, "read6");
  endtask
  task automatic test_write;
    do_write(16'h0010, 16'hBEEF, 1'b0, 1'b0, "wr_full");
    do_read(16'h0010, "rb_full");
  endtask
  task automatic test_lanes;
    preload(10'h010, 16'hBEEF);
    do_write(16'h0010, 16'h1200, 1'b0, 1'b1, "wr_ub");
    do_read(16'h0010, "rb_ub");
    do_write(16'h0010, 16'h00AB, 1'b1, 1'b0, "wr_lb");
    do_read(16'h0010, "rb_lb");
    do_write(16'h0010, 16'h9999, 1'b1, 1'b1, "wr_none");
    do_read(16'h0010, "rb_none");
  endtask
  task automatic test_abort;
    preload(10'h020, 16'h5555);
    drive(16'h0020, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    bus_idle;
    tick;
    chk("abort_busy", {15'b0, bus.Busy}, 16'h0);
    chk("abort_valid", {15'b0, bus.Data_valid}, 16'h0);
    do_read(16'h0020, "rb_abort");
  endtask
  task automatic test_init_collision;
    preload(10'h040, 16'h0F0F);
    drive(16'h0040, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    Init_en = 1'b1;
    Init_addr = 10'h041;
    Init_data = 16'h3333;
    mdl[10'h041] = 16'h3333;
    tick;
    Init_en = 1'b0;
    bus_idle;
    chk("coll_busy", {15'b0, bus.Busy}, 16'h0);
    tick;
    do_read(16'h0040, "rb_coll_bus");
    do_read(16'h0041, "rb_coll_init");
  endtask
  task automatic test_alias;
    do_read(16'h0405, "alias");
  endtask
  task automatic test_err;
    drive(16'h0005, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    bus_idle;
    chk("err_set", {15'b0, bus.Err}, 16'h1);
    chk("err_busy", {15'b0, bus.Busy}, 16'h0);
    tick;
    do_read(16'h0005, "err_traffic");
    chk("err_sticky", {15'b0, bus.Err}, 16'h1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("err_clr", {15'b0, bus.Err}, 16'h0);
    chk("err_rst_data", bus.Data_out, 16'h0);
  endtask
  task automatic test_reset_in_write;
    preload(10'h030, 16'hAAAA);
    drive(16'h0030, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    chk("rstwr_busy", {15'b0, bus.Busy}, 16'h1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    bus_idle;
    chk("rstwr_idle", {15'b0, bus.Busy}, 16'h0);
    tick;
    do_read(16'h0030, "rb_rstwr");
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      do_write(16'(16'h0080 + i), 16'($urandom_range(0, 65535)), 1'b0, 1'b0, "b2b_wr");
      do_read(16'(16'h0080 + i), "b2b_rd");
    end
  endtask
  initial begin
    bus.Addr = '0;
    bus.Data_in = '0;
    bus_idle;
    test_reset;
    test_read;
    test_write;
    test_lanes;
    test_abort;
    test_init_collision;
    test_alias;
    test_err;
    test_reset_in_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
